// File: rtl/main_note_engine.sv
// Note-control core: synchronizes keys/buttons/switch, applies transpose, latch, mute and panic,
// and registers the 27-bit active-note vector. Optional button debouncing via MAIN_NOTE_DEBOUNCE_EN.
module main_note_engine #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_SHIFT       = 12
) (
  input  logic        clk,
  input  logic        reset,
  output logic [26:0] note,
  input  logic [26:0] key,
  input  logic        b1,
  input  logic        b2,
  input  logic        b3,
  input  logic        b4,
  input  logic        b5,
  input  logic        sw1
);
  localparam int NK = 27;
  localparam int NB = 5;
  localparam int OW = $clog2(MAX_SHIFT + 1) + 1;

  localparam logic signed [OW-1:0] P_MAX = OW'(MAX_SHIFT);
  localparam logic signed [OW-1:0] P_MIN = -P_MAX;

  // Button index order: 0=b1 up, 1=b2 down, 2=b3 mute, 3=b4 panic, 4=b5 transpose reset
  localparam int BI_UP = 0, BI_DN = 1, BI_MUTE = 2, BI_PANIC = 3, BI_RST = 4;

  if (DEBOUNCE_CYCLES < 1 || MAX_SHIFT < 1 || MAX_SHIFT > NK - 1) begin : g_bad_param
    $error("main_note_engine: DEBOUNCE_CYCLES must be >= 1 and MAX_SHIFT in 1..26");
  end

  logic [NB-1:0] w_btn_raw;
  assign w_btn_raw = {b5, b4, b3, b2, b1};

  logic [NK-1:0] r_key_s1, r_key_s2, r_key_d;
  logic [NB-1:0] r_btn_s1, r_btn_s2;
  logic          r_sw_s1, r_sw_s2, r_sw_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_s1 <= '0;
      r_key_s2 <= '0;
      r_key_d  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= 1'b0;
      r_sw_s2  <= 1'b0;
      r_sw_d   <= 1'b0;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw1;
      r_sw_s2  <= r_sw_s1;
      r_sw_d   <= r_sw_s2;
    end
  end

  logic [NB-1:0] w_deb;

`ifdef MAIN_NOTE_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [NB-1:0][CW-1:0] r_cnt;
  logic [NB-1:0]         r_deb;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_deb <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (r_btn_s2[b] != r_deb[b]) begin
          if (r_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_deb[b] <= ~r_deb[b];
            r_cnt[b] <= '0;
          end else begin
            r_cnt[b] <= r_cnt[b] + CW'(1);
          end
        end else begin
          r_cnt[b] <= '0;
        end
      end
    end
  end

  assign w_deb = r_deb;
`else
  assign w_deb = r_btn_s2;
`endif

  logic [NB-1:0] r_deb_d;
  logic [NB-1:0] w_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_deb_d <= '0;
    else       r_deb_d <= w_deb;
  end

  assign w_evt = w_deb & ~r_deb_d;

  logic [NK-1:0] w_key_rise;
  logic          w_sw_chg;
  logic [NK-1:0] r_latch;

  assign w_key_rise = r_key_s2 & ~r_key_d;
  assign w_sw_chg   = r_sw_s2 ^ r_sw_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_latch <= '0;
    else if (w_evt[BI_PANIC] || w_sw_chg || !r_sw_s2)
      r_latch <= '0;
    else
      r_latch <= r_latch ^ w_key_rise;
  end

  logic signed [OW-1:0] r_off, w_off_nxt;
  logic                 r_mute, w_mute_nxt;

  always_comb begin
    w_off_nxt = r_off;
    if (w_evt[BI_PANIC] || w_evt[BI_RST])
      w_off_nxt = '0;
    else if (w_evt[BI_UP] && w_evt[BI_DN])
      w_off_nxt = r_off;
    else if (w_evt[BI_UP] && r_off != P_MAX)
      w_off_nxt = r_off + OW'(1);
    else if (w_evt[BI_DN] && r_off != P_MIN)
      w_off_nxt = r_off - OW'(1);
  end

  always_comb begin
    w_mute_nxt = r_mute;
    if (w_evt[BI_PANIC])     w_mute_nxt = 1'b0;
    else if (w_evt[BI_MUTE]) w_mute_nxt = ~r_mute;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_off  <= '0;
      r_mute <= 1'b0;
    end else begin
      r_off  <= w_off_nxt;
      r_mute <= w_mute_nxt;
    end
  end

  logic [NK-1:0] w_src, w_shift, w_note_nxt, r_note;
  logic [OW-1:0] w_mag;

  assign w_src = r_sw_s2 ? r_latch : r_key_s2;
  assign w_mag = r_off[OW-1] ? OW'(-r_off) : OW'(r_off);

  // Logical shifts drop notes pushed past either end of the keyboard
  assign w_shift    = r_off[OW-1] ? (w_src >> w_mag) : (w_src << w_mag);
  assign w_note_nxt = r_mute ? '0 : w_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_note <= '0;
    else       r_note <= w_note_nxt;
  end

  assign note = r_note;
endmodule

// File: tb/tb_main_note_engine.sv
// Self-checking bench for main_note_engine against a rule-level reference model.
module tb_main_note_engine;
  localparam int DB = 16;
  localparam int MS = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [26:0] note;
  logic [26:0] key = '1;
  logic        b1 = 1'b1, b2 = 1'b1, b3 = 1'b1, b4 = 1'b1, b5 = 1'b1;
  logic        sw1 = 1'b0;

  always #5 clk = ~clk;

  main_note_engine #(.DEBOUNCE_CYCLES(DB), .MAX_SHIFT(MS)) dut (
    .clk(clk), .reset(reset), .note(note), .key(key),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .sw1(sw1)
  );

  int          n_chk = 0, n_pass = 0;
  int          m_off = 0;
  bit          m_mute = 1'b0;
  logic [26:0] m_latch = '0;
  logic [26:0] exp_n;

  // Note i sounds when source key (i - offset) is held and not muted
  function automatic logic [26:0] model(input logic [26:0] s, input int off, input bit mute);
    logic [26:0] r;
    r = '0;
    if (!mute)
      for (int i = 0; i < 27; i++) begin
        int j;
        j = i - off;
        if (j >= 0 && j <= 26) r[i] = s[j];
      end
    return r;
  endfunction

  function automatic logic [26:0] cur_exp();
    return model(sw1 ? m_latch : key, m_off, m_mute);
  endfunction

  task automatic set_key(input logic [26:0] k);
    @(negedge clk);
    key = k;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] btn, input int hold);
    bit fires;
`ifdef MAIN_NOTE_DEBOUNCE_EN
    fires = (hold >= DB);
`else
    fires = (hold >= 1);
`endif
    @(negedge clk);
    {b5, b4, b3, b2, b1} = btn;
    repeat (hold) @(negedge clk);
    {b5, b4, b3, b2, b1} = '0;
    repeat (DB + 8) @(negedge clk);
    if (fires) begin
      if (btn[3]) begin
        m_off = 0; m_mute = 1'b0; m_latch = '0;
      end else begin
        if (btn[4]) m_off = 0;
        else if (btn[0] && !btn[1]) m_off = (m_off < MS) ? m_off + 1 : MS;
        else if (btn[1] && !btn[0]) m_off = (m_off > -MS) ? m_off - 1 : -MS;
        if (btn[2]) m_mute = !m_mute;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [26:0] m);
    @(negedge clk);
    key = m;
    repeat (4) @(negedge clk);
    key = '0;
    repeat (6) @(posedge clk);
    #1;
    m_latch = m_latch ^ m;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 10; k++) begin
      repeat (50) @(negedge clk);
      n_chk++;
      if (note !== 27'h0) $display("FAIL reset_hold note=%h expected=%h", note, 27'h0);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1'b0;
    key = '0;
    {b5, b4, b3, b2, b1} = '0;
    repeat (DB + 10) @(negedge clk);
    n_chk++;
    if (note !== 27'h0) $display("FAIL reset_release note=%h expected=%h", note, 27'h0);
    else n_pass++;
  endtask

  task automatic test_latency();
    @(negedge clk);
    key = 27'h1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (note !== 27'h0) $display("FAIL lat_on_early note=%h expected=%h", note, 27'h0);
    else n_pass++;
    @(posedge clk);
    #1;
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL lat_on note=%h expected=%h", note, exp_n);
    else n_pass++;
    @(negedge clk);
    key = 27'h0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (note !== exp_n) $display("FAIL lat_off_early note=%h expected=%h", note, exp_n);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if (note !== 27'h0) $display("FAIL lat_off note=%h expected=%h", note, 27'h0);
    else n_pass++;
  endtask

  task automatic test_transpose();
    set_key(27'h1);
    press(5'b00001, 500);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n || exp_n !== 27'h2) $display("FAIL tr_hold note=%h expected=%h", note, exp_n);
    else n_pass++;
    press(5'b00010, DB + 4);
    press(5'b00010, DB + 4);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL tr_key0_neg note=%h expected=%h", note, exp_n);
    else n_pass++;
    set_key(27'h1 << 5);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL tr_key5_neg note=%h expected=%h", note, exp_n);
    else n_pass++;
  endtask

  task automatic test_saturation();
    repeat (15) press(5'b00001, DB + 2);
    set_key(27'h1 << 14);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL sat_key14 note=%h expected=%h", note, exp_n);
    else n_pass++;
    set_key(27'h1 << 20);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL sat_key20 note=%h expected=%h", note, exp_n);
    else n_pass++;
    press(5'b10000, DB + 2);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL sat_b5 note=%h expected=%h", note, exp_n);
    else n_pass++;
    repeat (15) press(5'b00010, DB + 2);
    set_key(27'h1 << 5);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL sat_neg note=%h expected=%h", note, exp_n);
    else n_pass++;
    press(5'b10000, DB + 2);
  endtask

  task automatic test_latch();
    set_key(27'h0);
    @(negedge clk);
    sw1 = 1'b1;
    m_latch = '0;
    repeat (8) @(posedge clk);
    #1;
    tap(27'h1 << 3);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL latch_on note=%h expected=%h", note, exp_n);
    else n_pass++;
    tap(27'h1 << 3);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL latch_off note=%h expected=%h", note, exp_n);
    else n_pass++;
    tap(27'h1 << 7);
    press(5'b01000, DB + 2);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL latch_panic note=%h expected=%h", note, exp_n);
    else n_pass++;
    tap((27'h1 << 7) | (27'h1 << 2));
    press(5'b00100, DB + 2);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL mute_on note=%h expected=%h", note, exp_n);
    else n_pass++;
    press(5'b00100, DB + 2);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL mute_off note=%h expected=%h", note, exp_n);
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tap(27'($urandom));
      exp_n = cur_exp();
      n_chk++;
      if (note !== exp_n) $display("FAIL latch_rand%0d note=%h expected=%h", k, note, exp_n);
      else n_pass++;
    end
    @(negedge clk);
    sw1 = 1'b0;
    m_latch = '0;
    repeat (8) @(posedge clk);
    #1;
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL latch_exit note=%h expected=%h", note, exp_n);
    else n_pass++;
  endtask

  task automatic test_glitch_conflict();
    set_key(27'h1 << 13);
    press(5'b00001, DB - 1);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL glitch note=%h expected=%h", note, exp_n);
    else n_pass++;
    press(5'b00011, DB + 4);
    exp_n = cur_exp();
    n_chk++;
    if (note !== exp_n) $display("FAIL conflict note=%h expected=%h", note, exp_n);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 7))
        0, 1: press(5'b00001, DB + 2);
        2, 3: press(5'b00010, DB + 2);
        4:    press(5'b00100, DB + 2);
        5:    press(($urandom_range(0, 3) == 0) ? 5'b01000 : 5'b10000, DB + 2);
        default: set_key(27'($urandom));
      endcase
      exp_n = cur_exp();
      n_chk++;
      if (note !== exp_n) $display("FAIL rand%0d note=%h expected=%h off=%0d mute=%0d", k, note, exp_n, m_off, m_mute);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_transpose();
    test_saturation();
    test_latch();
    test_glitch_conflict();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
